load_store_unit: RTL and testbench
==================================

# load_store_unit

Byte-serial load/store unit that executes the memory phase of RV32I LB/LH/LW/LBU/LHU/SB/SH/SW once the control FSM has computed the effective address. It sits between the control FSM and the byte-wide RAM port: one request in, one byte per cycle out, one response back. Data is little-endian, and load results are sign- or zero-extended to 32 bits.

## Interface
- No parameters.
- `clk` input 1: sole clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `req_valid` input 1: request present.
- `req_ready` output 1: unit idle and able to accept.
- `req_write` input 1: 1 = store, 0 = load.
- `funct3` input 3: RV32I width/sign field.
- `addr` input 32: effective byte address.
- `wdata` input 32: store data (rs2 value).
- `rsp_valid` output 1: one-cycle completion pulse.
- `rsp_err` output 1: request rejected, no memory access; qualified by `rsp_valid`.
- `rdata` output 32: extended load result; held until the next acceptance.
- `mem_addr` output 32: byte address to RAM.
- `mem_we` output 1: byte write enable.
- `mem_wdata` output 8: byte to RAM.
- `mem_rdata` input 8: byte from RAM. Asynchronous read: valid in the same cycle `mem_addr` is driven.

## Operation
- States:
  - IDLE
  - ACCESS
  - DONE
- Reset values:
  - State is IDLE, byte counter 0.
  - `req_ready` 1; `rsp_valid`, `rsp_err`, `mem_we` 0.
  - `rdata`, `mem_addr`, `mem_wdata` all 0.
- Acceptance: `req_valid && req_ready` at a rising edge latches `req_write`, `funct3`, `addr` and `wdata`. Inputs are ignored outside IDLE.
- Legal funct3 for loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- Legal funct3 for stores: 000 SB, 001 SH, 010 SW.
- Byte count N is 1, 2 or 4, taken from funct3[1:0].
- Illegal funct3 (any other value) goes IDLE→DONE with `rsp_err`=1. No memory cycle is issued and `rdata` is unchanged.
- ACCESS: byte i (0..N-1) is on the bus for one cycle.
  - `mem_addr` = latched addr + i, modulo 2^32, so 0xFFFFFFFF+1 wraps to 0.
  - Store: `mem_we`=1 and `mem_wdata` = wdata[8i+7:8i].
  - Load: `mem_we`=0; `mem_rdata` is captured into byte i of an internal shift register at the edge ending that cycle.
  - After byte N-1 the FSM goes to DONE.
- Extension:
  - LB/LH replicate bit 7 / bit 15 into the upper bits.
  - LBU/LHU zero-fill the upper bits.
  - LW is unchanged.
  - `rdata` updates on entry to DONE.
- DONE: `rsp_valid`=1 for exactly one cycle, then IDLE. Stores do not alter `rdata`.
- `req_ready` = (state == IDLE), combinational from state.
- Outside ACCESS: `mem_we`=0 and `mem_addr` holds its last value.
- Misaligned addresses are legal by default: bytes are simply addr, addr+1, …

## Timing
- Request accepted at edge E0.
- Byte i is driven between E(i) and E(i+1).
- DONE spans EN to E(N+1); `rsp_valid` is high in that cycle.
- `req_ready` returns at E(N+1).
- Latency from acceptance to response:
  - LB/LBU/SB: 2 cycles.
  - LH/LHU/SH: 3 cycles.
  - LW/SW: 5 cycles.
  - Rejected request: 1 cycle.
- Back-to-back: a new request can be accepted at E(N+1), giving a throughput of N+1 cycles per access.
- A `req_valid` held high during ACCESS/DONE is not accepted until IDLE.
- Reset mid-operation:
  - Immediate return to IDLE and `mem_we` drops asynchronously.
  - Store bytes already written remain in RAM.
  - No `rsp_valid` is generated.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined:
  - Halfword with addr[0]≠0, or word with addr[1:0]≠0, is treated like an illegal funct3.
  - It is answered in 1 cycle with `rsp_err`=1 and no memory access.
- Not defined: misaligned accesses complete byte-serially with no error. `rsp_err` is asserted only for illegal funct3.

## Test plan
- LW, addr=0x80, RAM[0x80..0x83]=58 00 00 80:
  - `mem_addr` steps 0x80→0x83.
  - `rsp_valid` appears 5 cycles after acceptance.
  - `rdata`=0x80000058.
- LB and LBU at 0x83 (byte 0x80): LB gives `rdata`=0xFFFFFF80; LBU gives 0x00000080. Each responds in 2 cycles.
- SH, addr=0x79, wdata=0x12345678:
  - Writes 0x78 to 0x79 and 0x56 to 0x7A; 0x7B is untouched.
  - `rsp_valid` after 3 cycles with `rsp_err`=0.
  - With `LSU_MISALIGN_TRAP_EN`: `rsp_err`=1 after 1 cycle and no `mem_we`.
- SW at 0xFFFFFFFE, wdata=0xAABBCCDD: writes DD→0xFFFFFFFE, CC→0xFFFFFFFF, BB→0x0, AA→0x1 (address wrap).
- funct3=011 load, then funct3=100 store:
  - Each gives `rsp_valid`+`rsp_err`=1 one cycle after acceptance, with no memory activity.
  - `rdata` is unchanged.
- Reset mid-operation:
  - `rst_n` pulled low during byte 2 of an SW: `mem_we` is 0 immediately, with no `rsp_valid`.
  - Bytes 0–1 are written and bytes 2–3 are not.
  - After release, `req_ready`=1 and a subsequent LW completes normally.

Source files
------------

// File: rtl/load_store_unit_if.sv
// Request/response and byte-wide RAM signals of the load/store unit.
// The master side drives requests and models the RAM; the slave side is the unit.
interface load_store_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        rsp_valid;
    logic        rsp_err;
    logic [31:0] rdata;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;

    modport master (
        output req_valid, req_write, funct3, addr, wdata, mem_rdata,
        input  req_ready, rsp_valid, rsp_err, rdata, mem_addr, mem_we, mem_wdata
    );

    modport slave (
        input  req_valid, req_write, funct3, addr, wdata, mem_rdata,
        output req_ready, rsp_valid, rsp_err, rdata, mem_addr, mem_we, mem_wdata
    );
endinterface

// File: rtl/load_store_unit.sv
// Byte-serial RV32I load/store unit: one request, N bytes on a byte RAM port, one response.
// Optional LSU_MISALIGN_TRAP_EN rejects misaligned halfword/word accesses like an illegal funct3.
module load_store_unit (
    input  logic               clk,
    input  logic               rst_n,
    load_store_unit_if.slave   bus
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        err_q, err_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic        mem_we_q, mem_we_d;
    logic [7:0]  mem_wdata_q, mem_wdata_d;
    logic [31:0] rdata_q, rdata_d;

    logic        write_q, write_d;
    logic [2:0]  f3_q, f3_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] ld_q, ld_d;

    logic [31:0] ld_raw;
    logic [1:0]  cnt_nxt;
    logic        misalign;
    logic        illegal;

    function automatic logic [1:0] last_idx(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   last_idx = 2'd0;
            2'b01:   last_idx = 2'd1;
            default: last_idx = 2'd3;
        endcase
    endfunction

    function automatic logic bad_funct3(input logic wr, input logic [2:0] f3);
        if (wr)
            bad_funct3 = !(f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b010);
        else
            bad_funct3 = !(f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b010 ||
                           f3 == 3'b100 || f3 == 3'b101);
    endfunction

    function automatic logic [31:0] extend_load(input logic [2:0] f3, input logic [31:0] raw);
        case (f3)
            3'b000:  extend_load = {{24{raw[7]}}, raw[7:0]};
            3'b001:  extend_load = {{16{raw[15]}}, raw[15:0]};
            3'b100:  extend_load = {24'h000000, raw[7:0]};
            3'b101:  extend_load = {16'h0000, raw[15:0]};
            default: extend_load = raw;
        endcase
    endfunction

`ifdef LSU_MISALIGN_TRAP_EN
    assign misalign = (bus.funct3[1:0] == 2'b01 && bus.addr[0]) ||
                      (bus.funct3[1:0] == 2'b10 && bus.addr[1:0] != 2'b00);
`else
    assign misalign = 1'b0;
`endif

    assign illegal = bad_funct3(bus.req_write, bus.funct3) || misalign;
    assign cnt_nxt = cnt_q + 2'd1;

    // Assembled load word including the byte currently on mem_rdata.
    always_comb begin
        ld_raw = ld_q;
        ld_raw[{cnt_q, 3'b000} +: 8] = bus.mem_rdata;
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        mem_addr_d  = mem_addr_q;
        mem_we_d    = mem_we_q;
        mem_wdata_d = mem_wdata_q;
        rdata_d     = rdata_q;
        write_d     = write_q;
        f3_d        = f3_q;
        wdata_d     = wdata_q;
        ld_d        = ld_q;

        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    write_d = bus.req_write;
                    f3_d    = bus.funct3;
                    wdata_d = bus.wdata;
                    err_d   = illegal;
                    cnt_d   = 2'd0;
                    if (illegal) begin
                        state_d = DONE;
                    end else begin
                        state_d     = ACCESS;
                        mem_addr_d  = bus.addr;
                        mem_we_d    = bus.req_write;
                        mem_wdata_d = bus.wdata[7:0];
                    end
                end
            end
            ACCESS: begin
                if (!write_q)
                    ld_d = ld_raw;
                if (cnt_q == last_idx(f3_q)) begin
                    state_d  = DONE;
                    mem_we_d = 1'b0;
                    if (!write_q)
                        rdata_d = extend_load(f3_q, ld_raw);
                end else begin
                    cnt_d       = cnt_nxt;
                    mem_addr_d  = mem_addr_q + 32'd1;
                    mem_wdata_d = wdata_q[{cnt_nxt, 3'b000} +: 8];
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d  = IDLE;
                mem_we_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= 2'd0;
            err_q       <= 1'b0;
            mem_addr_q  <= 32'h0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= 8'h00;
            rdata_q     <= 32'h0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            mem_addr_q  <= mem_addr_d;
            mem_we_q    <= mem_we_d;
            mem_wdata_q <= mem_wdata_d;
            rdata_q     <= rdata_d;
        end
    end

    // Request fields and load bytes are only meaningful after acceptance.
    always_ff @(posedge clk) begin
        write_q <= write_d;
        f3_q    <= f3_d;
        wdata_q <= wdata_d;
        ld_q    <= ld_d;
    end

    assign bus.req_ready = (state_q == IDLE);
    assign bus.rsp_valid = (state_q == DONE);
    assign bus.rsp_err   = (state_q == DONE) && err_q;
    assign bus.rdata     = rdata_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a 256-byte RAM model indexed by mem_addr[7:0].
module tb_load_store_unit;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    load_store_unit_if bus();

    load_store_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [7:0] ram [256];
    logic       pre_we = 1'b0;
    logic [7:0] pre_a  = 8'h00;
    logic [7:0] pre_d  = 8'h00;

    assign bus.mem_rdata = ram[bus.mem_addr[7:0]];

    always @(posedge clk) begin
        if (bus.mem_we)
            ram[bus.mem_addr[7:0]] <= bus.mem_wdata;
        else if (pre_we)
            ram[pre_a] <= pre_d;
    end

    int checks = 0;
    int errors = 0;
    logic [31:0] cur_rdata;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic poke(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        pre_we = 1'b1;
        pre_a  = a;
        pre_d  = d;
        @(negedge clk);
        pre_we = 1'b0;
    endtask

    // n = 0 means the request must be rejected with rsp_err.
    task automatic access(input string tag, input logic wr, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd, input int n,
                          input logic [31:0] exp_rd);
        @(negedge clk);
        chk({tag, ".ready"}, {31'b0, bus.req_ready}, 32'd1);
        bus.req_valid = 1'b1;
        bus.req_write = wr;
        bus.funct3    = f3;
        bus.addr      = a;
        bus.wdata     = wd;
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.addr      = 32'h0;
        bus.wdata     = 32'h0;
        for (int i = 0; i < n; i++) begin
            chk({tag, ".addr"}, bus.mem_addr, a + 32'(i));
            chk({tag, ".we"}, {31'b0, bus.mem_we}, {31'b0, wr});
            if (wr)
                chk({tag, ".wdata"}, {24'b0, bus.mem_wdata}, {24'b0, wd[8*i +: 8]});
            chk({tag, ".early_rsp"}, {31'b0, bus.rsp_valid}, 32'd0);
            @(negedge clk);
        end
        chk({tag, ".rsp_valid"}, {31'b0, bus.rsp_valid}, 32'd1);
        chk({tag, ".rsp_err"}, {31'b0, bus.rsp_err}, (n == 0) ? 32'd1 : 32'd0);
        chk({tag, ".we_done"}, {31'b0, bus.mem_we}, 32'd0);
        chk({tag, ".rdata"}, bus.rdata, exp_rd);
        @(negedge clk);
        chk({tag, ".rsp_end"}, {31'b0, bus.rsp_valid}, 32'd0);
        chk({tag, ".ready_back"}, {31'b0, bus.req_ready}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.funct3    = 3'b000;
        bus.addr      = 32'h0;
        bus.wdata     = 32'h0;

        for (int i = 0; i < 256; i++)
            poke(8'(i), 8'h00);
        poke(8'h80, 8'h58);
        poke(8'h81, 8'h00);
        poke(8'h82, 8'h00);
        poke(8'h83, 8'h80);
        poke(8'h7B, 8'hEE);
        for (int i = 0; i < 4; i++)
            poke(8'hA0 + 8'(i), 8'h11);

        chk("rst.ready", {31'b0, bus.req_ready}, 32'd1);
        chk("rst.rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
        chk("rst.rsp_err", {31'b0, bus.rsp_err}, 32'd0);
        chk("rst.we", {31'b0, bus.mem_we}, 32'd0);
        chk("rst.rdata", bus.rdata, 32'h0);
        chk("rst.mem_addr", bus.mem_addr, 32'h0);
        chk("rst.mem_wdata", {24'b0, bus.mem_wdata}, 32'h0);

        @(negedge clk);
        rst_n = 1'b1;

        access("lw", 1'b0, 3'b010, 32'h80, 32'h0, 4, 32'h80000058);
        access("lb", 1'b0, 3'b000, 32'h83, 32'h0, 1, 32'hFFFFFF80);
        access("lbu", 1'b0, 3'b100, 32'h83, 32'h0, 1, 32'h00000080);
        access("lh", 1'b0, 3'b001, 32'h82, 32'h0, 2, 32'hFFFF8000);
        access("lhu", 1'b0, 3'b101, 32'h82, 32'h0, 2, 32'h00008000);
        cur_rdata = 32'h00008000;

`ifdef LSU_MISALIGN_TRAP_EN
        access("sh_mis", 1'b1, 3'b001, 32'h79, 32'h12345678, 0, cur_rdata);
        chk("sh.ram79", {24'b0, ram[8'h79]}, 32'h00);
        chk("sh.ram7A", {24'b0, ram[8'h7A]}, 32'h00);
        access("sw_wrap", 1'b1, 3'b010, 32'hFFFFFFFE, 32'hAABBCCDD, 0, cur_rdata);
        chk("sw.ramFE", {24'b0, ram[8'hFE]}, 32'h00);
        chk("sw.ram00", {24'b0, ram[8'h00]}, 32'h00);
`else
        access("sh_mis", 1'b1, 3'b001, 32'h79, 32'h12345678, 2, cur_rdata);
        chk("sh.ram79", {24'b0, ram[8'h79]}, 32'h78);
        chk("sh.ram7A", {24'b0, ram[8'h7A]}, 32'h56);
        access("sw_wrap", 1'b1, 3'b010, 32'hFFFFFFFE, 32'hAABBCCDD, 4, cur_rdata);
        chk("sw.ramFE", {24'b0, ram[8'hFE]}, 32'hDD);
        chk("sw.ramFF", {24'b0, ram[8'hFF]}, 32'hCC);
        chk("sw.ram00", {24'b0, ram[8'h00]}, 32'hBB);
        chk("sw.ram01", {24'b0, ram[8'h01]}, 32'hAA);
`endif
        chk("sh.ram7B", {24'b0, ram[8'h7B]}, 32'hEE);

        access("ill_ld011", 1'b0, 3'b011, 32'h80, 32'h0, 0, cur_rdata);
        access("ill_st100", 1'b1, 3'b100, 32'h90, 32'hFFFFFFFF, 0, cur_rdata);
        chk("ill.ram90", {24'b0, ram[8'h90]}, 32'h00);

        access("sb", 1'b1, 3'b000, 32'h90, 32'h123456A5, 1, cur_rdata);
        chk("sb.ram90", {24'b0, ram[8'h90]}, 32'hA5);
        chk("sb.ram91", {24'b0, ram[8'h91]}, 32'h00);

        // SW interrupted by reset during its third byte.
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.funct3    = 3'b010;
        bus.addr      = 32'hA0;
        bus.wdata     = 32'hDEADBEEF;
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rstmid.addr2", bus.mem_addr, 32'hA2);
        chk("rstmid.we2", {31'b0, bus.mem_we}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rstmid.we_drop", {31'b0, bus.mem_we}, 32'd0);
        chk("rstmid.rsp", {31'b0, bus.rsp_valid}, 32'd0);
        chk("rstmid.ready", {31'b0, bus.req_ready}, 32'd1);
        @(negedge clk);
        chk("rstmid.rsp2", {31'b0, bus.rsp_valid}, 32'd0);
        rst_n = 1'b1;
        chk("rstmid.ramA0", {24'b0, ram[8'hA0]}, 32'hEF);
        chk("rstmid.ramA1", {24'b0, ram[8'hA1]}, 32'hBE);
        chk("rstmid.ramA2", {24'b0, ram[8'hA2]}, 32'h11);
        chk("rstmid.ramA3", {24'b0, ram[8'hA3]}, 32'h11);
        chk("rstmid.rdata", bus.rdata, 32'h0);

        access("lw_after", 1'b0, 3'b010, 32'h80, 32'h0, 4, 32'h80000058);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
